// File: rtl/demux_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_pkg
// Description : Shared constants and holding-buffer state encoding for the
//               demux/dispatch arbitration blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_dispatch_pkg;

  localparam int c_DEF_DATA_WIDTH = 10;
  localparam int c_DEF_CNT_WIDTH  = 8;

  // Occupancy of the 2-entry in-order holding buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_dispatch_hold_buf2.sv
`default_nettype none
// ============================================================================
// Module      : hold_buf2
// Description : 2-entry in-order holding buffer with a bypass head. When
//               empty, the incoming word is presented as the head so it can
//               leave in the same cycle it arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_buf2
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic                  drop,
  output buf_state_t            state
);

  buf_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_e0;
  logic [DATA_WIDTH-1:0] r_e1;

  // Head is the oldest buffered word, or the incoming word when nothing is held
  assign head_valid = (r_state != ST_EMPTY) || in_valid;
  assign head_data  = (r_state == ST_EMPTY) ? in_data : r_e0;
  // A full buffer that cannot move its head has no room for a new word
  assign drop       = in_valid && (r_state == ST_FULL) && !pop;
  assign state      = r_state;

  // Occupancy update: dispatch frees the head first, then a new word is appended
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid && !pop) begin
            r_e0    <= in_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && in_valid) begin
            r_e0 <= in_data;
          end else if (pop) begin
            r_state <= ST_EMPTY;
          end else if (in_valid) begin
            r_e1    <= in_data;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            r_e0 <= r_e1;
            if (in_valid) begin
              r_e1 <= in_data;
            end else begin
              r_state <= ST_ONE;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch
// Description : Splits a muxed word stream onto two destination FIFOs using
//               the word's top bit, with head-of-line blocking on almost-full,
//               per-port push counters and a sticky drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = c_DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  afull_0,
  input  logic                  afull_1,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  push_0,
  output logic                  push_1,
  output logic                  pause,
  output logic [CNT_WIDTH-1:0]  cnt_0,
  output logic [CNT_WIDTH-1:0]  cnt_1,
  output logic                  err_drop
);

  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_valid;
  logic                  w_head_dest;
  logic                  w_dispatch;
  logic                  w_drop;
  buf_state_t            w_state;

  logic [DATA_WIDTH-1:0] r_data_out_0;
  logic [DATA_WIDTH-1:0] r_data_out_1;
  logic                  r_push_0;
  logic                  r_push_1;
  logic [CNT_WIDTH-1:0]  r_cnt_0;
  logic [CNT_WIDTH-1:0]  r_cnt_1;
  logic                  r_err_drop;

  hold_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold_buf2 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (data_in),
    .in_valid   (valid_in),
    .pop        (w_dispatch),
    .head_data  (w_head_data),
    .head_valid (w_head_valid),
    .drop       (w_drop),
    .state      (w_state)
  );

  // Only the head may leave; its own destination's almost-full gates it
  assign w_head_dest = w_head_data[DATA_WIDTH-1];
  assign w_dispatch  = w_head_valid && (w_head_dest ? !afull_1 : !afull_0);

  // Registered push strobes, data, counters and sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_push_0     <= 1'b0;
      r_push_1     <= 1'b0;
      r_data_out_0 <= '0;
      r_data_out_1 <= '0;
      r_cnt_0      <= '0;
      r_cnt_1      <= '0;
      r_err_drop   <= 1'b0;
    end else begin
      r_push_0   <= w_dispatch && !w_head_dest;
      r_push_1   <= w_dispatch && w_head_dest;
      r_err_drop <= r_err_drop | w_drop;
      if (w_dispatch && !w_head_dest) begin
        r_data_out_0 <= w_head_data;
        r_cnt_0      <= r_cnt_0 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_dispatch && w_head_dest) begin
        r_data_out_1 <= w_head_data;
        r_cnt_1      <= r_cnt_1 + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign data_out_0 = r_data_out_0;
  assign data_out_1 = r_data_out_1;
  assign push_0     = r_push_0;
  assign push_1     = r_push_1;
  assign cnt_0      = r_cnt_0;
  assign cnt_1      = r_cnt_1;
  assign err_drop   = r_err_drop;
  // Stall upstream whenever anything is held
  assign pause      = (w_state != ST_EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_dispatch
// Description : Directed scoreboard bench for demux_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_dispatch;

  localparam int DW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          afull_0;
  logic          afull_1;
  logic [DW-1:0] data_out_0;
  logic [DW-1:0] data_out_1;
  logic          push_0;
  logic          push_1;
  logic          pause;
  logic [CW-1:0] cnt_0;
  logic [CW-1:0] cnt_1;
  logic          err_drop;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected pushes: {port, word}
  logic [DW:0] exp_q[$];

  demux_dispatch #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .afull_0    (afull_0),
    .afull_1    (afull_1),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .push_0     (push_0),
    .push_1     (push_1),
    .pause      (pause),
    .cnt_0      (cnt_0),
    .cnt_1      (cnt_1),
    .err_drop   (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic port, input logic [DW-1:0] word);
    exp_q.push_back({port, word});
  endtask

  // Monitor: every push must match the oldest expected push
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset && (push_0 || push_1)) begin
      if (push_0 && push_1) begin
        check("both_ports_pushed", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_push", {push_1, (push_1 ? data_out_1 : data_out_0)}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("push_word", {push_1, (push_1 ? data_out_1 : data_out_0)}, {21'd0, e});
      end
    end
  end

  initial begin
    reset    = 1'b1;
    data_in  = '0;
    valid_in = 1'b0;
    afull_0  = 1'b0;
    afull_1  = 1'b0;
    #1;
    check("rst_push", {push_1, push_0}, 32'd0);
    check("rst_pause", pause, 0);
    check("rst_cnt", {cnt_1, cnt_0}, 32'd0);
    check("rst_data", {data_out_1, data_out_0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Bypass to port 0
    expect_push(1'b0, 10'h005);
    data_in = 10'h005; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("bypass_cnt_0", cnt_0, 1);
    check("bypass_pause", pause, 0);
    check("bypass_push_0", push_0, 1);

    // Alternate ports back-to-back
    expect_push(1'b1, 10'h201);
    expect_push(1'b0, 10'h002);
    data_in = 10'h201; valid_in = 1'b1;
    tick();
    data_in = 10'h002;
    tick();
    valid_in = 1'b0;
    tick();
    check("alt_cnt_0", cnt_0, 2);
    check("alt_cnt_1", cnt_1, 1);

    // Head-of-line blocking on port 1
    afull_1 = 1'b1;
    data_in = 10'h2AA; valid_in = 1'b1;
    tick();
    data_in = 10'h011;
    tick();
    valid_in = 1'b0;
    check("blk_pause_full", pause, 1);
    tick();
    tick();
    check("blk_no_push", {push_1, push_0}, 32'd0);
    expect_push(1'b1, 10'h2AA);
    expect_push(1'b0, 10'h011);
    afull_1 = 1'b0;
    tick();
    check("blk_pause_one", pause, 1);
    tick();
    check("blk_pause_empty", pause, 0);
    check("blk_cnt_0", cnt_0, 3);
    check("blk_cnt_1", cnt_1, 2);

    // Drop in FULL
    afull_0 = 1'b1;
    data_in = 10'h044; valid_in = 1'b1;
    tick();
    data_in = 10'h055;
    tick();
    check("drop_none_yet", err_drop, 0);
    data_in = 10'h033;
    tick();
    valid_in = 1'b0;
    check("drop_set", err_drop, 1);
    expect_push(1'b0, 10'h044);
    expect_push(1'b0, 10'h055);
    afull_0 = 1'b0;
    tick();
    tick();
    tick();
    check("drop_sticky", err_drop, 1);
    check("drop_cnt_0", cnt_0, 5);

    // Counter wrap: 251 more words to port 0 brings the total to 256
    for (int i = 0; i < 251; i++) begin
      logic [DW-1:0] w;
      w = DW'(i) & 10'h1FF;
      expect_push(1'b0, w);
      data_in = w; valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    tick();
    check("wrap_cnt_0", cnt_0, 0);

    // Reset while one word is held
    afull_0 = 1'b1;
    data_in = 10'h0AB; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("one_pause", pause, 1);
    #2 reset = 1'b1;
    #1;
    check("async_push", {push_1, push_0}, 32'd0);
    check("async_pause", pause, 0);
    check("async_cnt", {cnt_1, cnt_0}, 32'd0);
    check("async_err", err_drop, 0);
    check("async_data", {data_out_1, data_out_0}, 32'd0);
    afull_0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    tick();
    check("post_rst_pause", pause, 0);

    // Normal operation on the first edges after reset
    expect_push(1'b1, 10'h3FF);
    data_in = 10'h3FF; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check("post_rst_push_1", push_1, 1);
    check("post_rst_cnt_1", cnt_1, 1);
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_dispatch.md
DEMUX_DISPATCH -- requirements
Module: demux_dispatch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, word width including the destination bit.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the per-port push counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  muxed word from the arbitrated stream; bit DATA_WIDTH-1 selects the destination.
REQ-006 SHALL have port valid_in  input  1  data_in holds a word this cycle.
REQ-007 SHALL have ports afull_0, afull_1  input  1 each  almost-full flags from destination FIFOs 0 and 1.
REQ-008 SHALL have ports data_out_0, data_out_1  output  DATA_WIDTH each  registered word to destination FIFO 0 / 1.
REQ-009 SHALL have ports push_0, push_1  output  1 each  registered write strobe to destination FIFO 0 / 1.
REQ-010 SHALL have port pause  output  1  upstream stall request.
REQ-011 SHALL have ports cnt_0, cnt_1  output  CNT_WIDTH each  words pushed to port 0 / 1.
REQ-012 SHALL have port err_drop  output  1  sticky flag; a word was lost.

Function
REQ-013 SHALL route by dest = data_in[DATA_WIDTH-1]: dest 0 -> port 0, dest 1 -> port 1; words forwarded unmodified, destination bit included.
REQ-014 SHALL hold words in a 2-entry in-order holding buffer; state EMPTY (0 words), ONE (1), FULL (2).
REQ-015 Dispatch rule, each cycle: if the head word exists (buffered, or valid_in while EMPTY) and afull of its destination is 0 -> next edge drives push_d=1 and data_out_d=word, and removes the word.
REQ-016 Otherwise both push outputs SHALL be 0 the next cycle; data_out_x SHALL hold its last value.
REQ-017 Latency SHALL be exactly 1 cycle from a sampled valid_in to push when EMPTY and the target is not almost full (bypass path).
REQ-018 Head-of-line blocking: a blocked head SHALL block all later words; never reorder, never push both ports in one cycle.
REQ-019 Accept: valid_in SHALL be enqueued if occupancy after this cycle's dispatch is below 2; enqueue and dispatch in the same cycle are permitted.
REQ-020 Drop: valid_in in FULL with no dispatch that cycle -> word discarded, err_drop set to 1 at the next edge and held until reset.
REQ-021 Transitions: EMPTY->ONE (accept, no dispatch); ONE->FULL (accept, no dispatch); FULL->ONE (dispatch, no accept); ONE->EMPTY (dispatch, no accept); otherwise state unchanged.
REQ-022 pause SHALL be 1 whenever state is ONE or FULL, 0 in EMPTY (decoded from registered state).
REQ-023 cnt_x SHALL increment by 1 on each cycle push_x=1 and wrap from 2^CNT_WIDTH-1 to 0.
REQ-024 afull changes SHALL take effect on the dispatch decision of the same cycle.

Reset
REQ-025 While reset=1: state EMPTY, push_0=push_1=0, data_out_0=data_out_1=0, pause=0, cnt_0=cnt_1=0, err_drop=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard buffered words without pushing them.
REQ-027 On the first edge after reset deasserts, normal accept/dispatch rules SHALL apply.

Structure
REQ-028 SHALL put the state encodings (EMPTY/ONE/FULL) and the default DATA_WIDTH/CNT_WIDTH constants in a shared package used by the arbitration blocks.
REQ-029 SHALL place the 2-entry holding buffer in sub-module hold_buf2; routing, counters and flags stay in demux_dispatch.

Verification (DATA_WIDTH=10, CNT_WIDTH=8)
REQ-030 valid_in=1, data_in=0x005, afull both 0 -> next cycle push_0=1, data_out_0=0x005, push_1=0, cnt_0=1, pause=0.
REQ-031 data_in 0x201 then 0x002 on consecutive cycles -> push_1 with 0x201, then push_0 with 0x002, one cycle each.
REQ-032 afull_1=1, send 0x2AA then 0x011 -> state FULL, pause=1, no push while blocked. Then afull_1=0 -> push_1 0x2AA, next cycle push_0 0x011; state returns to EMPTY.
REQ-033 Blocked in FULL (afull_0=1) with a third valid_in 0x033 -> err_drop=1 and stays 1; after unblock only the two buffered words are pushed.
REQ-034 256 words to port 0 -> cnt_0 wraps to 0; assert reset while in ONE -> all outputs zero immediately, no push of the buffered word.
